// File: rtl/axi_write_dispatch_fsm_if.sv
// AXI4 write-channel bundle (AW, W, B) between the interconnect slave port
// and the write dispatch FSM. Only the signals the dispatcher uses are carried.
interface axi_write_dispatch_fsm_if;
  logic [3:0]  axs_s0_awid;
  logic [31:0] axs_s0_awaddr;
  logic [7:0]  axs_s0_awlen;
  logic [2:0]  axs_s0_awsize;
  logic [1:0]  axs_s0_awburst;
  logic        axs_s0_awvalid;
  logic        axs_s0_awready;
  logic [31:0] axs_s0_wdata;
  logic [3:0]  axs_s0_wstrb;
  logic        axs_s0_wvalid;
  logic        axs_s0_wready;
  logic        axs_s0_bready;
  logic [3:0]  axs_s0_bid;
  logic        axs_s0_bvalid;

  // Interconnect side: issues addresses/data, accepts responses.
  modport master (
    output axs_s0_awid, axs_s0_awaddr, axs_s0_awlen, axs_s0_awsize,
           axs_s0_awburst, axs_s0_awvalid,
           axs_s0_wdata, axs_s0_wstrb, axs_s0_wvalid, axs_s0_bready,
    input  axs_s0_awready, axs_s0_wready, axs_s0_bid, axs_s0_bvalid
  );

  // Dispatcher side.
  modport slave (
    input  axs_s0_awid, axs_s0_awaddr, axs_s0_awlen, axs_s0_awsize,
           axs_s0_awburst, axs_s0_awvalid,
           axs_s0_wdata, axs_s0_wstrb, axs_s0_wvalid, axs_s0_bready,
    output axs_s0_awready, axs_s0_wready, axs_s0_bid, axs_s0_bvalid
  );
endinterface

// File: rtl/axi_write_dispatch_fsm.sv
// AXI4 write-channel slave control. Accepts one write burst at a time and
// steers each beat to either the varint input FIFO group or the raw-data
// input FIFO group (selected by awaddr[SEL_BIT]), then returns a B response.
module axi_write_dispatch_fsm #(
  parameter int SEL_BIT = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  axi_write_dispatch_fsm_if.slave     axs_s0,
  input  logic                        varint_in_fifo_full,
  output logic                        varint_in_fifo_clr,
  output logic                        varint_in_index_clr,
  output logic                        varint_in_fifo_push,
  output logic                        varint_in_index_push,
  input  logic                        raw_data_in_fifo_full,
  output logic                        raw_data_in_fifo_clr,
  output logic                        raw_data_in_index_clr,
  output logic                        raw_data_in_wstrb_clr,
  output logic                        raw_data_in_fifo_push,
  output logic                        raw_data_in_index_push,
  output logic                        raw_data_in_wstrb_push,
  output logic [31:0]                 wdata,
  output logic [3:0]                  wstrb,
  output logic [9:0]                  index
);

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    AW_READY = 2'd1,
    W_READY  = 2'd2,
    B_RESP   = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [3:0]  bid_reg;
  logic [7:0]  beats_left;
  logic        fixed_burst;
  logic        target;
  logic [9:0]  idx_reg;

  logic        aw_fire;
  logic        w_fire;
  logic        target_full;
  logic        wready_int;

  // Handshake qualifiers; wready is combinational on the selected FIFO's full.
  assign target_full = target ? raw_data_in_fifo_full : varint_in_fifo_full;
  assign wready_int  = (state_q == W_READY) && !target_full;
  assign aw_fire     = (state_q == AW_READY) && axs_s0.axs_s0_awvalid;
  assign w_fire      = wready_int && axs_s0.axs_s0_wvalid;

  // State register; reset abandons any in-flight burst without a response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:     state_d = AW_READY;
      AW_READY: if (aw_fire) state_d = W_READY;
      W_READY:  if (w_fire && (beats_left == 8'd0)) state_d = B_RESP;
      B_RESP:   if (axs_s0.axs_s0_bready) state_d = AW_READY;
      default:  state_d = INIT;
    endcase
  end

  // Burst context: captured on AW, advanced on every accepted beat.
  // Always loaded before use, so it carries no reset.
  always_ff @(posedge clk) begin
    if (aw_fire) begin
      bid_reg     <= axs_s0.axs_s0_awid;
      beats_left  <= axs_s0.axs_s0_awlen;
      fixed_burst <= (axs_s0.axs_s0_awburst == 2'b00);
      target      <= axs_s0.axs_s0_awaddr[SEL_BIT];
      idx_reg     <= axs_s0.axs_s0_awaddr[11:2];
    end else if (w_fire) begin
      beats_left  <= beats_left - 8'd1;
      if (!fixed_burst) begin
        idx_reg <= idx_reg + 10'd1;
      end
    end
  end

  // Output decode: clears in INIT, handshakes/pushes/data by state.
  always_comb begin
    varint_in_fifo_clr     = 1'b0;
    varint_in_index_clr    = 1'b0;
    raw_data_in_fifo_clr   = 1'b0;
    raw_data_in_index_clr  = 1'b0;
    raw_data_in_wstrb_clr  = 1'b0;
    varint_in_fifo_push    = 1'b0;
    varint_in_index_push   = 1'b0;
    raw_data_in_fifo_push  = 1'b0;
    raw_data_in_index_push = 1'b0;
    raw_data_in_wstrb_push = 1'b0;
    axs_s0.axs_s0_awready  = 1'b0;
    axs_s0.axs_s0_wready   = 1'b0;
    axs_s0.axs_s0_bvalid   = 1'b0;
    axs_s0.axs_s0_bid      = 4'd0;
    wdata                  = 32'd0;
    wstrb                  = 4'd0;
    index                  = 10'd0;
    unique case (state_q)
      INIT: begin
        varint_in_fifo_clr    = 1'b1;
        varint_in_index_clr   = 1'b1;
        raw_data_in_fifo_clr  = 1'b1;
        raw_data_in_index_clr = 1'b1;
        raw_data_in_wstrb_clr = 1'b1;
      end
      AW_READY: begin
        axs_s0.axs_s0_awready = 1'b1;
      end
      W_READY: begin
        axs_s0.axs_s0_wready = wready_int;
        wdata                = axs_s0.axs_s0_wdata;
        wstrb                = axs_s0.axs_s0_wstrb;
        index                = idx_reg;
        if (w_fire) begin
          if (target) begin
            raw_data_in_fifo_push  = 1'b1;
            raw_data_in_index_push = 1'b1;
            raw_data_in_wstrb_push = 1'b1;
          end else begin
            varint_in_fifo_push    = 1'b1;
            varint_in_index_push   = 1'b1;
          end
        end
      end
      B_RESP: begin
        axs_s0.axs_s0_bvalid = 1'b1;
        axs_s0.axs_s0_bid    = bid_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_write_dispatch_fsm.sv
// Bench for axi_write_dispatch_fsm: directed bursts, a transaction-level
// model that predicts every output each cycle, and literal spot checks.
module tb_axi_write_dispatch_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic varint_in_fifo_full = 1'b0;
  logic raw_data_in_fifo_full = 1'b0;
  logic varint_in_fifo_clr, varint_in_index_clr;
  logic varint_in_fifo_push, varint_in_index_push;
  logic raw_data_in_fifo_clr, raw_data_in_index_clr, raw_data_in_wstrb_clr;
  logic raw_data_in_fifo_push, raw_data_in_index_push, raw_data_in_wstrb_push;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [9:0]  index;

  axi_write_dispatch_fsm_if bus();

  axi_write_dispatch_fsm #(.SEL_BIT(12)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .axs_s0                 (bus.slave),
    .varint_in_fifo_full    (varint_in_fifo_full),
    .varint_in_fifo_clr     (varint_in_fifo_clr),
    .varint_in_index_clr    (varint_in_index_clr),
    .varint_in_fifo_push    (varint_in_fifo_push),
    .varint_in_index_push   (varint_in_index_push),
    .raw_data_in_fifo_full  (raw_data_in_fifo_full),
    .raw_data_in_fifo_clr   (raw_data_in_fifo_clr),
    .raw_data_in_index_clr  (raw_data_in_index_clr),
    .raw_data_in_wstrb_clr  (raw_data_in_wstrb_clr),
    .raw_data_in_fifo_push  (raw_data_in_fifo_push),
    .raw_data_in_index_push (raw_data_in_index_push),
    .raw_data_in_wstrb_push (raw_data_in_wstrb_push),
    .wdata                  (wdata),
    .wstrb                  (wstrb),
    .index                  (index)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [9:0]  exp_idx_q[$];
  bit          m_active = 0;
  bit          m_tgt = 0;
  logic [3:0]  m_id = 4'd0;
  int          post_rst = 0;

  // Observed push log for literal checks
  logic [9:0]  log_idx[$];
  bit          log_tgt[$];
  logic [31:0] log_data[$];
  int          bv_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_clr", {varint_in_fifo_clr, varint_in_index_clr, raw_data_in_fifo_clr,
                      raw_data_in_index_clr, raw_data_in_wstrb_clr}, 32'h1f);
      chk("rst_push", {varint_in_fifo_push, varint_in_index_push, raw_data_in_fifo_push,
                       raw_data_in_index_push, raw_data_in_wstrb_push}, 32'h0);
      chk("rst_hs", {bus.axs_s0_awready, bus.axs_s0_wready, bus.axs_s0_bvalid}, 32'h0);
      chk("rst_data", {wdata, wstrb, index, bus.axs_s0_bid} == '0, 32'h1);
      exp_idx_q.delete();
      m_active = 0;
      post_rst = 0;
    end else begin
      bit in_init, w_ph, b_ph, e_aw, e_wr, e_acc, tfull;
      logic [9:0] base;
      in_init = (post_rst == 0);
      w_ph    = m_active && (exp_idx_q.size() > 0);
      b_ph    = m_active && (exp_idx_q.size() == 0);
      e_aw    = !in_init && !m_active;
      tfull   = m_tgt ? raw_data_in_fifo_full : varint_in_fifo_full;
      e_wr    = w_ph && !tfull;
      e_acc   = e_wr && bus.axs_s0_wvalid;

      chk("clr", {varint_in_fifo_clr, varint_in_index_clr, raw_data_in_fifo_clr,
                  raw_data_in_index_clr, raw_data_in_wstrb_clr}, in_init ? 32'h1f : 32'h0);
      chk("awready", bus.axs_s0_awready, e_aw);
      chk("wready", bus.axs_s0_wready, e_wr);
      chk("varint_push", {varint_in_fifo_push, varint_in_index_push},
          (e_acc && !m_tgt) ? 32'h3 : 32'h0);
      chk("raw_push", {raw_data_in_fifo_push, raw_data_in_index_push, raw_data_in_wstrb_push},
          (e_acc && m_tgt) ? 32'h7 : 32'h0);
      chk("wdata", wdata, w_ph ? bus.axs_s0_wdata : 32'h0);
      chk("wstrb", wstrb, w_ph ? bus.axs_s0_wstrb : 4'h0);
      chk("index", index, w_ph ? exp_idx_q[0] : 10'h0);
      chk("bvalid", bus.axs_s0_bvalid, b_ph);
      chk("bid", bus.axs_s0_bid, b_ph ? m_id : 4'h0);

      if (varint_in_fifo_push || raw_data_in_fifo_push) begin
        log_idx.push_back(index);
        log_tgt.push_back(raw_data_in_fifo_push);
        log_data.push_back(wdata);
      end
      if (bus.axs_s0_bvalid) bv_cnt++;

      if (e_acc) void'(exp_idx_q.pop_front());
      if (b_ph && bus.axs_s0_bready) m_active = 0;
      if (e_aw && bus.axs_s0_awvalid) begin
        m_active = 1;
        m_id     = bus.axs_s0_awid;
        m_tgt    = bus.axs_s0_awaddr[12];
        base     = bus.axs_s0_awaddr[11:2];
        for (int k = 0; k <= int'(bus.axs_s0_awlen); k++) begin
          if (bus.axs_s0_awburst == 2'b00) exp_idx_q.push_back(base);
          else                             exp_idx_q.push_back(base + 10'(k));
        end
      end
      post_rst++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_bus();
    bus.axs_s0_awid = 4'd0; bus.axs_s0_awaddr = 32'd0; bus.axs_s0_awlen = 8'd0;
    bus.axs_s0_awsize = 3'b010; bus.axs_s0_awburst = 2'b01; bus.axs_s0_awvalid = 1'b0;
    bus.axs_s0_wdata = 32'd0; bus.axs_s0_wstrb = 4'd0; bus.axs_s0_wvalid = 1'b0;
    bus.axs_s0_bready = 1'b0;
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [1:0] burst, input logic [2:0] size);
    bit ok = 0;
    bus.axs_s0_awid = id; bus.axs_s0_awaddr = addr; bus.axs_s0_awlen = len;
    bus.axs_s0_awburst = burst; bus.axs_s0_awsize = size; bus.axs_s0_awvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.axs_s0_awready) begin ok = 1; break; end
    end
    chk("aw_timeout", ok, 1);
    @(posedge clk); #1;
    bus.axs_s0_awvalid = 1'b0;
  endtask

  task automatic do_beat(input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    bus.axs_s0_wvalid = 1'b1; bus.axs_s0_wdata = d; bus.axs_s0_wstrb = s;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.axs_s0_wready) begin ok = 1; break; end
    end
    chk("w_timeout", ok, 1);
    @(posedge clk); #1;
    bus.axs_s0_wvalid = 1'b0;
  endtask

  task automatic do_b(input logic [3:0] id);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.axs_s0_bvalid) begin ok = 1; break; end
    end
    chk("b_timeout", ok, 1);
    chk("b_id_lit", bus.axs_s0_bid, id);
    @(negedge clk);
    chk("b_hold", bus.axs_s0_bvalid, 1);
    @(posedge clk); #1;
    bus.axs_s0_bready = 1'b1;
    @(posedge clk); #1;
    bus.axs_s0_bready = 1'b0;
  endtask

  task automatic reset_log();
    log_idx.delete(); log_tgt.delete(); log_data.delete();
  endtask

  initial begin
    idle_bus();
    // Reset held 4 cycles
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("lit_rst_clr", raw_data_in_wstrb_clr, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("lit_post1_clr", varint_in_fifo_clr, 1);
    chk("lit_post1_awready", bus.axs_s0_awready, 0);
    @(negedge clk);
    chk("lit_post2_clr", raw_data_in_fifo_clr, 0);
    chk("lit_post2_awready", bus.axs_s0_awready, 1);
    @(posedge clk); #1;

    // Single varint beat
    reset_log();
    do_aw(4'd6, 32'h0000_00F1, 8'd0, 2'b00, 3'b010);
    do_beat(32'hDEAD_BEEF, 4'hF);
    do_b(4'd6);
    chk("lit_v1_cnt", log_idx.size(), 1);
    if (log_idx.size() == 1) begin
      chk("lit_v1_idx", log_idx[0], 10'h3C);
      chk("lit_v1_tgt", log_tgt[0], 0);
      chk("lit_v1_data", log_data[0], 32'hDEAD_BEEF);
    end

    // Raw INCR burst of 4
    reset_log();
    do_aw(4'd2, 32'h0000_1000, 8'd3, 2'b01, 3'b010);
    for (int k = 0; k < 4; k++) do_beat(32'h1000_0000 + k, 4'hF);
    do_b(4'd2);
    chk("lit_raw_cnt", log_idx.size(), 4);
    for (int k = 0; k < 4 && k < log_idx.size(); k++) begin
      chk("lit_raw_idx", log_idx[k], k);
      chk("lit_raw_tgt", log_tgt[k], 1);
    end

    // Same raw burst with a 3-cycle full stall before beat 2
    reset_log();
    do_aw(4'd3, 32'h0000_1000, 8'd3, 2'b01, 3'b010);
    do_beat(32'hA0, 4'h1);
    do_beat(32'hA1, 4'h3);
    bus.axs_s0_wvalid = 1'b1; bus.axs_s0_wdata = 32'hA2; bus.axs_s0_wstrb = 4'h7;
    raw_data_in_fifo_full = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("lit_stall_wready", bus.axs_s0_wready, 0);
    end
    @(posedge clk); #1;
    raw_data_in_fifo_full = 1'b0;
    do_beat(32'hA2, 4'h7);
    do_beat(32'hA3, 4'hF);
    do_b(4'd3);
    chk("lit_stall_cnt", log_idx.size(), 4);
    if (log_idx.size() == 4) begin
      chk("lit_stall_d2", log_data[2], 32'hA2);
      chk("lit_stall_i3", log_idx[3], 10'd3);
    end

    // FIXED varint burst of 3 at 0x10
    reset_log();
    do_aw(4'd7, 32'h0000_0010, 8'd2, 2'b00, 3'b010);
    for (int k = 0; k < 3; k++) do_beat(32'h5500 + k, 4'hF);
    do_b(4'd7);
    chk("lit_fix_cnt", log_idx.size(), 3);
    for (int k = 0; k < log_idx.size(); k++) chk("lit_fix_idx", log_idx[k], 10'd4);

    // Index wrap, awburst 11 behaves as INCR, odd awsize, early wvalid ignored
    reset_log();
    bus.axs_s0_wvalid = 1'b1; bus.axs_s0_wdata = 32'h77; bus.axs_s0_wstrb = 4'h2;
    do_aw(4'd15, 32'h0000_0FFC, 8'd1, 2'b11, 3'b000);
    chk("lit_wrap_early", log_idx.size(), 0);
    do_beat(32'hB0, 4'h2);
    do_beat(32'hB1, 4'h4);
    do_b(4'd15);
    chk("lit_wrap_cnt", log_idx.size(), 2);
    if (log_idx.size() == 2) begin
      chk("lit_wrap_i0", log_idx[0], 10'd1023);
      chk("lit_wrap_i1", log_idx[1], 10'd0);
    end

    // Abort: reset in the middle of a raw burst
    reset_log();
    do_aw(4'd9, 32'h0000_1000, 8'd3, 2'b01, 3'b010);
    do_beat(32'hC0, 4'hF);
    bus.axs_s0_wvalid = 1'b1; bus.axs_s0_wdata = 32'hC1;
    #3;
    reset = 1'b1;
    bus.axs_s0_wvalid = 1'b0;
    @(negedge clk);
    chk("lit_abort_clr", varint_in_index_clr, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    bv_cnt = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("lit_abort_bv", bv_cnt, 0);
    chk("lit_abort_pushes", log_idx.size(), 1);

    // Recovery after abort
    reset_log();
    do_aw(4'd1, 32'h0000_0008, 8'd0, 2'b01, 3'b010);
    do_beat(32'h1234_5678, 4'hF);
    do_b(4'd1);
    chk("lit_rec_cnt", log_idx.size(), 1);
    if (log_idx.size() == 1) chk("lit_rec_idx", log_idx[0], 10'd2);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
